cpu_rst_seq: RTL

Reset sequencer that sits directly downstream of the PLL clock stage. It consumes the PLL `clk_lock` flag and the board push-button, and produces the CPU core's active-low reset `cpu_rst_n`. Reset is released only after lock has been stable for a programmable hold time, and is re-asserted on lock loss or a debounced button press. Lock-loss events are also recorded for debug.

---
 rtl/cpu_rst_seq_if.sv | 28 ++
 rtl/cpu_rst_seq.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/cpu_rst_seq_if.sv
// Signal bundle between the reset sequencer and its environment:
// PLL lock and push-button in, CPU reset and lock-loss debug state out.
interface cpu_rst_seq_if;
    logic       clk_lock;
    logic       btn_rst;
    logic       cpu_rst_n;
    logic       lock_lost;
    logic [7:0] lost_cnt;
    logic [1:0] state;

    modport master (
        output clk_lock,
        output btn_rst,
        input  cpu_rst_n,
        input  lock_lost,
        input  lost_cnt,
        input  state
    );

    modport slave (
        input  clk_lock,
        input  btn_rst,
        output cpu_rst_n,
        output lock_lost,
        output lost_cnt,
        output state
    );
endinterface

// File: rtl/cpu_rst_seq.sv
// CPU reset sequencer: releases cpu_rst_n once PLL lock has been stable for
// HOLD_CYCLES, re-asserts on lock loss or a debounced button press.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// WAIT_LOCK | CPU in reset, waiting for synchronized lock
// HOLD      | lock seen, counting HOLD_CYCLES (button keeps count at 0)
// RUN       | CPU out of reset
module cpu_rst_seq #(
    parameter int HOLD_CYCLES     = 16,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic          pll_clk,
    input  logic          fpga_rst_n,
    cpu_rst_seq_if.slave  bus
);

    localparam int HW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [HW-1:0]   hold_cnt;
    logic [HW-1:0]   hold_cnt_d;
    logic            lost_evt;

    logic            lock_meta;
    logic            lock_s;
    logic            btn_meta;
    logic            btn_s;
    logic [DW-1:0]   db_cnt;
    logic            btn_db;

    logic            cpu_rst_n_q;
    logic            lock_lost_q;
    logic [7:0]      lost_cnt_q;

    // Both asynchronous inputs get a plain two-flop synchronizer.
    always_ff @(posedge pll_clk or negedge fpga_rst_n) begin
        if (!fpga_rst_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
            btn_meta  <= 1'b0;
            btn_s     <= 1'b0;
        end else begin
            lock_meta <= bus.clk_lock;
            lock_s    <= lock_meta;
            btn_meta  <= bus.btn_rst;
            btn_s     <= btn_meta;
        end
    end

    always_ff @(posedge pll_clk or negedge fpga_rst_n) begin
        if (!fpga_rst_n) begin
            db_cnt <= '0;
            btn_db <= 1'b0;
        end else if (btn_s != btn_db) begin
            if (db_cnt == DB_LAST) begin
                btn_db <= ~btn_db;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end else begin
            db_cnt <= '0;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt;
        lost_evt   = 1'b0;
        case (state_q)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d    = HOLD;
                    hold_cnt_d = '0;
                end
            end
            HOLD: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (btn_db) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_d = RUN;
                end else begin
                    hold_cnt_d = hold_cnt + 1'b1;
                end
            end
            RUN: begin
                // Lock loss wins over a simultaneous button press.
                if (!lock_s) begin
                    state_d  = WAIT_LOCK;
                    lost_evt = 1'b1;
                end else if (btn_db) begin
                    state_d    = HOLD;
                    hold_cnt_d = '0;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
            end
        endcase
    end

    always_ff @(posedge pll_clk or negedge fpga_rst_n) begin
        if (!fpga_rst_n) begin
            state_q     <= WAIT_LOCK;
            hold_cnt    <= '0;
            cpu_rst_n_q <= 1'b0;
            lock_lost_q <= 1'b0;
            lost_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            hold_cnt    <= hold_cnt_d;
            cpu_rst_n_q <= (state_d == RUN);
            if (lost_evt) begin
                lock_lost_q <= 1'b1;
                if (lost_cnt_q != 8'hFF) begin
                    lost_cnt_q <= lost_cnt_q + 8'd1;
                end
            end
        end
    end

    assign bus.cpu_rst_n = cpu_rst_n_q;
    assign bus.lock_lost = lock_lost_q;
    assign bus.lost_cnt  = lost_cnt_q;
    assign bus.state     = state_q;

endmodule
